emif_result_reader: RTL and testbench

//  Return-path counterpart of the EMIF register-sampling block. Core logic hands
//  it a DATA_W-bit result word with a valid/ready handshake. The word is held in
//  a shadow buffer and the DSP reads it back over the EMIF as BUS_W-bit halfwords.
//  A status location reports full/overrun. The buffer frees itself once every

---
 rtl/emif_result_reader.sv | 177 +++++++++++++++++
 tb/tb_emif_result_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/emif_result_reader.sv
// emif_result_reader
// Holds one DATA_W-bit result word from core logic in a shadow buffer. The DSP
// reads it back over an asynchronous EMIF as BUS_W-bit halfwords. The buffer
// frees itself once every halfword has been read at least once. One extra
// address returns a status word that reports overrun and full.
module emif_result_reader #(
    parameter int DATA_W = 320,
    parameter int BUS_W  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic              emif_ce_n,
    input  logic              emif_oe_n,
    input  logic [ADDR_W-1:0] emif_addr,
    output logic [BUS_W-1:0]  emif_rdata,
    output logic              emif_rdata_oe,
    output logic              buf_full,
    output logic              rd_done,
    output logic              led_busy
);

    localparam int                NWORDS      = DATA_W / BUS_W;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NWORDS);
    localparam logic [NWORDS-1:0] MASK_ALL    = {NWORDS{1'b1}};
    localparam logic [NWORDS-1:0] MASK_ONE    = NWORDS'(1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Returns halfword idx of the shadow word; idx 0 is the least significant.
    function automatic logic [BUS_W-1:0] sel_halfword(input logic [DATA_W-1:0] word,
                                                      input logic [ADDR_W-1:0] idx);
        sel_halfword = word[int'(idx) * BUS_W +: BUS_W];
    endfunction

    // EMIF pin synchronisers. The third oe_n stage is used for falling-edge detection.
    logic              ce_s1_r, ce_s2_r;
    logic              oe_s1_r, oe_s2_r, oe_s3_r;
    logic [ADDR_W-1:0] addr_s1_r, addr_s2_r;

    // State and registered outputs
    state_t            state_r;
    logic [DATA_W-1:0] shadow_r;
    logic [NWORDS-1:0] read_mask_r;
    logic              overrun_r;
    logic [BUS_W-1:0]  emif_rdata_r;
    logic              emif_rdata_oe_r;
    logic              res_ready_r;
    logic              buf_full_r;
    logic              rd_done_r;

    // Decoded read-event signals
    logic              read_evt_s;
    logic              word_hit_s;
    logic              status_hit_s;
    logic [NWORDS-1:0] mask_bit_s;
    logic [NWORDS-1:0] mask_next_s;
    logic [BUS_W-1:0]  rd_word_s;
    logic              ov_set_s;
    logic              ov_clr_s;

    // Bring the asynchronous EMIF strobes and address into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_s1_r   <= 1'b1;
            ce_s2_r   <= 1'b1;
            oe_s1_r   <= 1'b1;
            oe_s2_r   <= 1'b1;
            oe_s3_r   <= 1'b1;
            addr_s1_r <= {ADDR_W{1'b0}};
            addr_s2_r <= {ADDR_W{1'b0}};
        end else begin
            ce_s1_r   <= emif_ce_n;
            ce_s2_r   <= ce_s1_r;
            oe_s1_r   <= emif_oe_n;
            oe_s2_r   <= oe_s1_r;
            oe_s3_r   <= oe_s2_r;
            addr_s1_r <= emif_addr;
            addr_s2_r <= addr_s1_r;
        end
    end

    // Decode the read event, the address map and the next read mask.
    always_comb begin
        read_evt_s   = 1'b0;
        word_hit_s   = 1'b0;
        status_hit_s = 1'b0;
        mask_bit_s   = {NWORDS{1'b0}};
        rd_word_s    = {BUS_W{1'b0}};
        if (!ce_s2_r && !oe_s2_r && oe_s3_r) begin
            read_evt_s = 1'b1;
        end else begin
            read_evt_s = 1'b0;
        end
        if (addr_s2_r < STATUS_ADDR) begin
            word_hit_s = 1'b1;
            mask_bit_s = MASK_ONE << addr_s2_r;
            rd_word_s  = sel_halfword(shadow_r, addr_s2_r);
        end else if (addr_s2_r == STATUS_ADDR) begin
            status_hit_s = 1'b1;
            rd_word_s    = {{(BUS_W-2){1'b0}}, overrun_r, buf_full_r};
        end else begin
            rd_word_s = {BUS_W{1'b0}};
        end
        mask_next_s = read_mask_r | mask_bit_s;
        ov_set_s    = (state_r == ST_FULL) && res_valid;
        ov_clr_s    = read_evt_s && status_hit_s;
    end

    // Main state machine: capture, read tracking, overrun flag and EMIF read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_EMPTY;
            shadow_r        <= {DATA_W{1'b0}};
            read_mask_r     <= {NWORDS{1'b0}};
            overrun_r       <= 1'b0;
            emif_rdata_r    <= {BUS_W{1'b0}};
            emif_rdata_oe_r <= 1'b0;
            res_ready_r     <= 1'b1;
            buf_full_r      <= 1'b0;
            rd_done_r       <= 1'b0;
        end else begin
            rd_done_r       <= 1'b0;
            emif_rdata_oe_r <= !ce_s2_r && !oe_s2_r;
            if (read_evt_s) begin
                emif_rdata_r <= rd_word_s;
            end
            // A set in the same cycle as a status-read clear wins.
            if (ov_set_s) begin
                overrun_r <= 1'b1;
            end else if (ov_clr_s) begin
                overrun_r <= 1'b0;
            end
            case (state_r)
                ST_EMPTY: begin
                    if (res_valid) begin
                        shadow_r    <= res_data;
                        read_mask_r <= {NWORDS{1'b0}};
                        state_r     <= ST_FULL;
                        res_ready_r <= 1'b0;
                        buf_full_r  <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (read_evt_s && word_hit_s) begin
                        read_mask_r <= mask_next_s;
                        if (mask_next_s == MASK_ALL) begin
                            state_r     <= ST_EMPTY;
                            rd_done_r   <= 1'b1;
                            res_ready_r <= 1'b1;
                            buf_full_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    res_ready_r <= 1'b1;
                    buf_full_r  <= 1'b0;
                end
            endcase
        end
    end

    assign res_ready     = res_ready_r;
    assign buf_full      = buf_full_r;
    assign led_busy      = buf_full_r;
    assign rd_done       = rd_done_r;
    assign emif_rdata    = emif_rdata_r;
    assign emif_rdata_oe = emif_rdata_oe_r;

endmodule

// File: tb/tb_emif_result_reader.sv
// Self-checking bench for emif_result_reader. Expected read data is pushed to
// a scoreboard queue when an EMIF read is started and is popped when the read
// data appears on emif_rdata.
module tb_emif_result_reader;

    logic         clk;
    logic         rst;
    logic [319:0] res_data;
    logic         res_valid;
    logic         res_ready;
    logic         emif_ce_n;
    logic         emif_oe_n;
    logic [4:0]   emif_addr;
    logic [15:0]  emif_rdata;
    logic         emif_rdata_oe;
    logic         buf_full;
    logic         rd_done;
    logic         led_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int ready_cnt = 0;
    logic ready_win = 1'b0;
    logic [15:0] exp_q[$];

    emif_result_reader dut (
        .clk           (clk),
        .rst           (rst),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .emif_ce_n     (emif_ce_n),
        .emif_oe_n     (emif_oe_n),
        .emif_addr     (emif_addr),
        .emif_rdata    (emif_rdata),
        .emif_rdata_oe (emif_rdata_oe),
        .buf_full      (buf_full),
        .rd_done       (rd_done),
        .led_busy      (led_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rd_done pulse cycles and res_ready cycles inside an observation window.
    always @(negedge clk) begin
        if (rd_done) done_cnt++;
        if (ready_win && res_ready) ready_cnt++;
    end

    // Watchdog against a hung run.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected run to end earlier");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] make_pat(input logic [15:0] base);
        logic [319:0] w;
        w = '0;
        for (int i = 0; i < 20; i++) w[i*16 +: 16] = base + 16'(i);
        return w;
    endfunction

    // One EMIF read: strobe low, wait the synchroniser latency, compare, strobe high.
    task automatic emif_read(input logic [4:0] a, input logic [15:0] exp, input string tag);
        exp_q.push_back(exp);
        @(negedge clk);
        emif_addr = a;
        emif_ce_n = 1'b0;
        emif_oe_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq({tag, " oe"}, 32'(emif_rdata_oe), 32'd1);
        if (exp_q.size() == 0) begin
            check_eq({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            check_eq(tag, 32'(emif_rdata), 32'(exp_q.pop_front()));
        end
        emif_oe_n = 1'b1;
        emif_ce_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic capture(input logic [319:0] w, input string tag);
        @(negedge clk);
        res_data  = w;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        check_eq({tag, " buf_full"}, 32'(buf_full), 32'd1);
        check_eq({tag, " res_ready"}, 32'(res_ready), 32'd0);
    endtask

    initial begin
        int base;
        logic [319:0] w;
        rst       = 1'b0;
        res_data  = '0;
        res_valid = 1'b0;
        emif_ce_n = 1'b1;
        emif_oe_n = 1'b1;
        emif_addr = 5'd0;

        // 1 Reset values
        repeat (3) @(negedge clk);
        check_eq("rst res_ready", 32'(res_ready), 32'd1);
        check_eq("rst buf_full", 32'(buf_full), 32'd0);
        check_eq("rst led_busy", 32'(led_busy), 32'd0);
        check_eq("rst rdata_oe", 32'(emif_rdata_oe), 32'd0);
        check_eq("rst rdata", 32'(emif_rdata), 32'd0);
        check_eq("rst rd_done", 32'(rd_done), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 2 Capture 100, read all, one rd_done after addr 19
        capture(320'd100, "t2 cap");
        check_eq("t2 led_busy", 32'(led_busy), 32'd1);
        emif_read(5'd0, 16'h0064, "t2 addr0");
        for (int i = 1; i < 19; i++) emif_read(5'(i), 16'h0000, $sformatf("t2 addr%0d", i));
        check_eq("t2 no early rd_done", 32'(done_cnt), 32'd0);
        check_eq("t2 still full", 32'(buf_full), 32'd1);
        emif_read(5'd19, 16'h0000, "t2 addr19");
        check_eq("t2 rd_done once", 32'(done_cnt), 32'd1);
        check_eq("t2 buf_full", 32'(buf_full), 32'd0);
        check_eq("t2 res_ready", 32'(res_ready), 32'd1);
        // stale read in EMPTY, unmapped address, status when empty
        emif_read(5'd0, 16'h0064, "t2 stale addr0");
        emif_read(5'd25, 16'h0000, "t2 unmapped");
        emif_read(5'd20, 16'h0000, "t2 status empty");
        check_eq("t2 stale no effect", 32'(buf_full), 32'd0);

        // 3 Pattern, addr 5 three times, then the rest in reverse
        capture(make_pat(16'hA500), "t3 cap");
        base = done_cnt;
        for (int k = 0; k < 3; k++) emif_read(5'd5, 16'hA505, $sformatf("t3 addr5 #%0d", k));
        for (int i = 19; i >= 0; i--) begin
            if (i != 5) begin
                if (i == 0) check_eq("t3 no early rd_done", 32'(done_cnt), 32'(base));
                emif_read(5'(i), 16'hA500 + 16'(i), $sformatf("t3 addr%0d", i));
            end
        end
        check_eq("t3 rd_done once", 32'(done_cnt), 32'(base + 1));
        check_eq("t3 buf_full", 32'(buf_full), 32'd0);

        // 4 Overrun while FULL
        capture(make_pat(16'h1100), "t4 cap");
        @(negedge clk);
        res_data  = make_pat(16'h9900);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        emif_read(5'd20, 16'h0003, "t4 status1");
        emif_read(5'd20, 16'h0001, "t4 status2");
        emif_read(5'd3, 16'h1103, "t4 shadow kept");
        base = done_cnt;
        for (int i = 0; i < 19; i++) emif_read(5'(i), 16'h1100 + 16'(i), $sformatf("t4 addr%0d", i));
        check_eq("t4 no rd_done", 32'(done_cnt), 32'(base));

        // 5 Final read coinciding with res_valid
        ready_cnt = 0;
        ready_win = 1'b1;
        res_data  = make_pat(16'h2200);
        res_valid = 1'b1;
        emif_read(5'd19, 16'h1113, "t5 addr19");
        @(negedge clk);
        res_valid = 1'b0;
        ready_win = 1'b0;
        check_eq("t5 ready one cycle", 32'(ready_cnt), 32'd1);
        check_eq("t5 rd_done", 32'(done_cnt), 32'(base + 1));
        check_eq("t5 refilled", 32'(buf_full), 32'd1);
        emif_read(5'd20, 16'h0003, "t5 status1");
        emif_read(5'd20, 16'h0001, "t5 status2");
        emif_read(5'd0, 16'h2200, "t5 new word");

        // 6 Reset after 10 halfwords, mid-read
        for (int i = 1; i < 10; i++) emif_read(5'(i), 16'h2200 + 16'(i), $sformatf("t6 addr%0d", i));
        @(negedge clk);
        emif_addr = 5'd10;
        emif_ce_n = 1'b0;
        emif_oe_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("t6 oe before rst", 32'(emif_rdata_oe), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("t6 rst oe", 32'(emif_rdata_oe), 32'd0);
        check_eq("t6 rst rdata", 32'(emif_rdata), 32'd0);
        check_eq("t6 rst buf_full", 32'(buf_full), 32'd0);
        check_eq("t6 rst res_ready", 32'(res_ready), 32'd1);
        @(negedge clk);
        emif_ce_n = 1'b1;
        emif_oe_n = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        emif_read(5'd20, 16'h0000, "t6 status cleared");
        emif_read(5'd0, 16'h0000, "t6 shadow cleared");
        w = make_pat(16'h3300);
        capture(w, "t6 cap");
        base = done_cnt;
        for (int i = 0; i < 19; i++) emif_read(5'(i), 16'h3300 + 16'(i), $sformatf("t6 addr%0d", i));
        check_eq("t6 no early rd_done", 32'(done_cnt), 32'(base));
        check_eq("t6 still full", 32'(buf_full), 32'd1);
        emif_read(5'd19, 16'h3313, "t6 addr19");
        check_eq("t6 rd_done", 32'(done_cnt), 32'(base + 1));
        check_eq("t6 buf_full", 32'(buf_full), 32'd0);
        check_eq("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
